// File: rtl/cnt_pass_seq.sv
// cnt_pass_seq: multi-pass step sequencer driving the step counter enable/clear strobes.
// Optional SEQ_PERF_EN adds perf_stall_cnt, a saturating count of stalled RUN cycles.
module cnt_pass_seq #(
  parameter int CNT_W  = 5,
  parameter int PASS_W = 4
) (
  input  logic              seq_clk,
  input  logic              seq_rst_n,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic              seq_stall,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              step_vld,
  output logic [CNT_W-1:0]  step_idx,
  output logic [PASS_W-1:0] pass_idx,
  output logic              seq_busy,
  output logic              seq_done
`ifdef SEQ_PERF_EN
  ,output logic [15:0]      perf_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] len_q, len_n, s_q, s_n, step_idx_n;
  logic [PASS_W-1:0] passes_q, passes_n, p_q, p_n, pass_idx_n;
  logic en_n, clr_n, vld_n, busy_n, done_n, last, wrap;
  // s_q/p_q name the next step to issue; the outputs show the step issued last.
  assign last = step_vld && step_idx == len_q && pass_idx == passes_q;
  assign wrap = s_q == len_q;
  always_comb begin
    state_n = state;
    len_n = len_q;
    passes_n = passes_q;
    s_n = s_q;
    p_n = p_q;
    step_idx_n = step_idx;
    pass_idx_n = pass_idx;
    en_n = 1'b0;
    clr_n = 1'b0;
    vld_n = 1'b0;
    done_n = 1'b0;
    busy_n = seq_busy;
    if (seq_abort) begin
      state_n = IDLE;
      clr_n = 1'b1;
      busy_n = 1'b0;
      s_n = '0;
      p_n = '0;
      step_idx_n = '0;
      pass_idx_n = '0;
    end else if (state == IDLE) begin
      if (seq_start) begin
        state_n = RUN;
        len_n = cfg_len;
        passes_n = cfg_passes;
        clr_n = 1'b1;
        busy_n = 1'b1;
        s_n = '0;
        p_n = '0;
        step_idx_n = '0;
        pass_idx_n = '0;
      end
    end else if (state == RUN) begin
      if (last) begin
        state_n = DONE;
        done_n = 1'b1;
      end else if (!seq_stall) begin
        vld_n = 1'b1;
        en_n = 1'b1;
        step_idx_n = s_q;
        pass_idx_n = p_q;
        clr_n = s_q == '0 && p_q != '0;
        s_n = wrap ? '0 : s_q + 1'b1;
        p_n = wrap ? p_q + 1'b1 : p_q;
      end
    end else begin
      state_n = IDLE;
      busy_n = 1'b0;
    end
  end
  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state <= IDLE;
      len_q <= '0;
      passes_q <= '0;
      s_q <= '0;
      p_q <= '0;
      step_idx <= '0;
      pass_idx <= '0;
      cnt_en <= 1'b0;
      cnt_clr <= 1'b0;
      step_vld <= 1'b0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      passes_q <= passes_n;
      s_q <= s_n;
      p_q <= p_n;
      step_idx <= step_idx_n;
      pass_idx <= pass_idx_n;
      cnt_en <= en_n;
      cnt_clr <= clr_n;
      step_vld <= vld_n;
      seq_busy <= busy_n;
      seq_done <= done_n;
    end
  end
`ifdef SEQ_PERF_EN
  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) perf_stall_cnt <= '0;
    else if (state == IDLE && seq_start && !seq_abort) perf_stall_cnt <= '0;
    else if (state == RUN && seq_stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end
`endif
endmodule
